// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT load path: size defaults, derived widths,
// load sequencer states and the index bit-reversal helper.
package ntt_pkg;

  localparam int LOG_N_DEF    = 12;
  localparam int LOG_CORE_DEF = 3;

  function automatic int calc_nb(input int log_core);
    return 2 ** (log_core + 1);
  endfunction

  function automatic int calc_aw(input int log_n, input int log_core);
    return log_n - log_core - 1;
  endfunction

  typedef enum logic [2:0] {
    LOAD,
    FLUSH,
    KICK,
    RUN,
    DONE
  } load_state_t;

  // Reverses the low 'width' bits of x; bits at and above 'width' come back zero.
  function automatic logic [31:0] bitrev(input logic [31:0] x, input int width);
    logic [31:0] r;
    r = '0;
    for (int unsigned b = 0; b < 32; b++) begin
      if (b < unsigned'(width)) r[b] = x[unsigned'(width) - 1 - b];
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_load_ctrl_bank_map.sv
// Coefficient index to bank enable / bank address mapping.
// Optional input bit-reversal when NTT_LOAD_BITREV_EN is defined.
module ntt_bank_map
  import ntt_pkg::*;
#(
  parameter  int LOG_N    = LOG_N_DEF,
  parameter  int LOG_CORE = LOG_CORE_DEF,
  localparam int NB       = calc_nb(LOG_CORE),
  localparam int AW       = calc_aw(LOG_N, LOG_CORE)
) (
  input  logic [LOG_N-1:0] idx,
  output logic [NB-1:0]    bank_we,
  output logic [AW-1:0]    bank_addr
);

  logic [LOG_N-1:0] j;

  always_comb begin
`ifdef NTT_LOAD_BITREV_EN
    j = LOG_N'(bitrev(32'(idx), LOG_N));
`else
    j = idx;
`endif
  end

  // Low bits pick the bank, the remaining high bits are the row inside it.
  always_comb begin
    bank_we                 = '0;
    bank_we[j[LOG_CORE:0]]  = 1'b1;
    bank_addr               = j[LOG_N-1:LOG_CORE+1];
  end

endmodule

// File: rtl/ntt_load_ctrl.sv
// Polynomial load sequencer: scatters N streamed coefficients into the NTT banks,
// kicks the Controller and waits for it to finish. Option macro: NTT_LOAD_BITREV_EN.
module ntt_load_ctrl
  import ntt_pkg::*;
#(
  parameter  int LOG_N    = LOG_N_DEF,
  parameter  int LOG_CORE = LOG_CORE_DEF,
  parameter  int COEF_W   = 32,
  localparam int NB       = calc_nb(LOG_CORE),
  localparam int AW       = calc_aw(LOG_N, LOG_CORE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [COEF_W-1:0] s_data,
  input  logic              s_last,
  output logic [NB-1:0]     mem_we,
  output logic [AW-1:0]     mem_waddr,
  output logic [COEF_W-1:0] mem_wdata,
  output logic              ntt_start,
  input  logic              ntt_finished,
  output logic              busy,
  output logic              done,
  output logic              err_last
);

  localparam logic [LOG_N-1:0] LAST_IDX = '1;

  load_state_t      state, state_nxt;
  logic [LOG_N-1:0] cnt;
  logic             hs;
  logic             at_last;
  logic [NB-1:0]    map_we;
  logic [AW-1:0]    map_addr;

  ntt_bank_map #(
    .LOG_N    (LOG_N),
    .LOG_CORE (LOG_CORE)
  ) u_bank_map (
    .idx       (cnt),
    .bank_we   (map_we),
    .bank_addr (map_addr)
  );

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    ntt_start = 1'b0;
    done      = 1'b0;
    at_last   = (cnt == LAST_IDX);
    case (state)
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid && at_last) state_nxt = FLUSH;
      end
      FLUSH: state_nxt = KICK;
      KICK: begin
        ntt_start = 1'b1;
        state_nxt = RUN;
      end
      RUN:  if (ntt_finished) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
    hs   = s_valid & s_ready;
    busy = !((state == LOAD) && (cnt == '0));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= LOAD;
      cnt       <= '0;
      mem_we    <= '0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      err_last  <= 1'b0;
    end else begin
      state  <= state_nxt;
      mem_we <= hs ? map_we : '0;
      if (hs) begin
        mem_waddr <= map_addr;
        mem_wdata <= s_data;
        cnt       <= cnt + LOG_N'(1);
        if (s_last != at_last) err_last <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ntt_load_ctrl.sv
// Randomized bench for ntt_load_ctrl (N=64, 4 banks) against a timeline-based reference model.
module tb_ntt_load_ctrl;

  localparam int LOG_N    = 6;
  localparam int LOG_CORE = 1;
  localparam int COEF_W   = 32;
  localparam int N        = 64;
  localparam int NBANK    = 4;
`ifdef NTT_LOAD_BITREV_EN
  localparam int EXP37_ADDR = 10;
`else
  localparam int EXP37_ADDR = 9;
`endif

  logic              clk;
  logic              reset;
  logic              s_valid;
  logic              s_ready;
  logic [COEF_W-1:0] s_data;
  logic              s_last;
  logic [3:0]        mem_we;
  logic [3:0]        mem_waddr;
  logic [COEF_W-1:0] mem_wdata;
  logic              ntt_start;
  logic              ntt_finished;
  logic              busy;
  logic              done;
  logic              err_last;

  ntt_load_ctrl #(
    .LOG_N    (LOG_N),
    .LOG_CORE (LOG_CORE),
    .COEF_W   (COEF_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .ntt_start    (ntt_start),
    .ntt_finished (ntt_finished),
    .busy         (busy),
    .done         (done),
    .err_last     (err_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: period counter plus the timestamps of the last beat and
  // of the accepted finish; everything else is derived from those.
  int          k;
  bit          loading;
  int          mcnt;
  bit          merr;
  int          t_last;
  int          u_fin;
  bit          pend_we;
  int          pend_j;
  logic [31:0] pend_d;
  bit          chk37;
  int          wr_cnt;
  int          start_cnt;

  function automatic int map_j(input int i);
`ifdef NTT_LOAD_BITREV_EN
    int r;
    r = 0;
    for (int b = 0; b < LOG_N; b++) r = r * 2 + ((i >> b) & 1);
    return r;
`else
    return i;
`endif
  endfunction

  task automatic model_reset();
    loading = 1'b1;
    mcnt    = 0;
    merr    = 1'b0;
    t_last  = -1000;
    u_fin   = -1000;
    pend_we = 1'b0;
    chk37   = 1'b0;
  endtask

  task automatic cycle(input bit v, input logic [31:0] d, input bit last, input bit fin,
                       input bit rst_n, output bit hs);
    chk("s_ready",   32'(s_ready),   32'(loading));
    chk("ntt_start", 32'(ntt_start), 32'(k == t_last + 2));
    chk("done",      32'(done),      32'(u_fin > t_last && k == u_fin + 1));
    chk("busy",      32'(busy),      32'(!(loading && mcnt == 0)));
    chk("err_last",  32'(err_last),  32'(merr));
    chk("mem_we",    32'(mem_we),    pend_we ? 32'(1 << (pend_j % NBANK)) : 32'd0);
    if (pend_we) begin
      chk("mem_waddr", 32'(mem_waddr), 32'(pend_j / NBANK));
      chk("mem_wdata", mem_wdata, pend_d);
    end
    if (chk37) begin
      chk("beat37_we",   32'(mem_we),    32'd2);
      chk("beat37_addr", 32'(mem_waddr), 32'(EXP37_ADDR));
      chk("beat37_data", mem_wdata,      32'd37);
    end
    if (mem_we != 4'd0) wr_cnt++;
    if (ntt_start) start_cnt++;

    s_valid      = v;
    s_data       = d;
    s_last       = last;
    ntt_finished = fin;
    reset        = rst_n;
    @(posedge clk);
    #1;

    hs = rst_n && v && loading;
    if (!rst_n) begin
      model_reset();
    end else begin
      pend_we = hs;
      chk37   = 1'b0;
      if (hs) begin
        pend_j = map_j(mcnt);
        pend_d = d;
        chk37  = (mcnt == 37 && d == 32'd37);
        if (last != (mcnt == N - 1)) merr = 1'b1;
        if (mcnt == N - 1) begin
          loading = 1'b0;
          t_last  = k;
          mcnt    = 0;
        end else begin
          mcnt++;
        end
      end else if (!loading && k >= t_last + 3 && u_fin < t_last && fin) begin
        u_fin = k;
      end else if (!loading && u_fin > t_last && k == u_fin + 1) begin
        loading = 1'b1;
      end
    end
    k++;
  endtask

  // vpct < 0 selects valid on every other cycle; abort_at >= 0 pulses reset after that many beats.
  task automatic poly(input int vpct, input int bad_idx, input int fin_delay,
                      input bit idx_data, input int abort_at);
    int          idx;
    int          guard;
    int          ws;
    int          ss;
    bit          hs;
    bit          v;
    bit          fin;
    logic [31:0] d;
    idx   = 0;
    guard = 0;
    ws    = wr_cnt;
    ss    = start_cnt;
    while (loading && guard < 2000) begin
      v = (vpct < 0) ? (guard % 2 == 0) : ($urandom_range(99) < vpct);
      d = idx_data ? 32'(idx) : $urandom;
      cycle(v, d, (idx == N - 1) || (idx == bad_idx), 1'($urandom_range(1)), 1'b1, hs);
      if (hs) idx++;
      guard++;
      if (abort_at >= 0 && idx == abort_at) begin
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, hs);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we",   32'(mem_we), 32'd0);
        return;
      end
    end
    while (!loading && guard < 2000) begin
      fin = (k < t_last + 3) ? 1'($urandom_range(1)) : (k == t_last + 3 + fin_delay);
      cycle(1'($urandom_range(1)), $urandom, 1'($urandom_range(1)), fin, 1'b1, hs);
      guard++;
    end
    chk("no_timeout", 32'(guard < 2000), 32'd1);
    chk("write_count", 32'(wr_cnt - ws), 32'(N));
    chk("start_count", 32'(start_cnt - ss), 32'd1);
  endtask

  initial begin
    bit hs;
    n_tests      = 0;
    n_fail       = 0;
    reset        = 1'b0;
    s_valid      = 1'b0;
    s_data       = '0;
    s_last       = 1'b0;
    ntt_finished = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    model_reset();
    k         = 0;
    wr_cnt    = 0;
    start_cnt = 0;

    chk("rst_s_ready",   32'(s_ready),   32'd1);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_mem_waddr", 32'(mem_waddr), 32'd0);
    chk("rst_mem_wdata", mem_wdata,      32'd0);
    chk("rst_ntt_start", 32'(ntt_start), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_err_last",  32'(err_last),  32'd0);

    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, hs);

    poly(100, -1, 20, 1'b1, -1);
    chk("err_clean", 32'(err_last), 32'd0);

    poly(-1, -1, 3, 1'b0, -1);

    poly(100, 10, 5, 1'b1, -1);
    chk("err_sticky", 32'(err_last), 32'd1);

    poly(100, -1, 0, 1'b1, 30);
    chk("err_after_rst", 32'(err_last), 32'd0);
    poly(100, -1, 2, 1'b1, -1);

    for (int p = 0; p < 3; p++) poly(60, -1, $urandom_range(10), 1'b0, -1);

    for (int c = 0; c < 3; c++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, hs);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ntt_load_ctrl.md
# ntt_load_ctrl

Polynomial load sequencer that sits directly upstream of the NTT `Controller`. It accepts a stream of coefficients over a valid/ready handshake and scatters them into the `2*NTT_CORE` coefficient banks at the bank/address layout the `Controller` reads from. Once all `N` coefficients have been written, it issues the single-cycle `start` pulse to the `Controller` and waits for its `finished`. It then reports completion and re-arms for the next polynomial.

## Interface

Parameters:
- `LOG_N`, default 12: log2 ring size; `N = 2**LOG_N` coefficients per polynomial.
- `LOG_CORE`, default 3: log2 butterfly count; `NB = 2**(LOG_CORE+1)` banks.
- `COEF_W`, default 32: coefficient width.
- Derived value `AW = LOG_N-LOG_CORE-1` is the bank address width, the same width as the `Controller` `raddr`.

Ports:
- `clk` — in — 1 — single clock, rising edge.
- `reset` — in — 1 — synchronous, active-low.
- `s_valid` — in — 1 — input coefficient valid.
- `s_ready` — out — 1 — block can accept a coefficient.
- `s_data` — in — `COEF_W` — coefficient value.
- `s_last` — in — 1 — marks coefficient `N-1`; used only for checking.
- `mem_we` — out — `NB` — one-hot bank write enable.
- `mem_waddr` — out — `AW` — bank write address.
- `mem_wdata` — out — `COEF_W` — bank write data.
- `ntt_start` — out — 1 — one-cycle pulse to the `Controller` `start` input.
- `ntt_finished` — in — 1 — `Controller` `finished`.
- `busy` — out — 1 — high in every state except `LOAD` with a count of 0.
- `done` — out — 1 — one-cycle pulse when the transform completes.
- `err_last` — out — 1 — sticky `s_last` framing error.

## Operation

- The FSM has five states: `LOAD`, `FLUSH`, `KICK`, `RUN`, `DONE`. The reset state is `LOAD`.
- **`LOAD`:**
  - `s_ready` is 1.
  - On each handshake (`s_valid & s_ready`), the beat at index `i` (counter value) is registered for writing, and the counter increments.
  - On the handshake at `i = N-1`: the counter wraps to 0 and the next state is `FLUSH`.
- **`FLUSH`:** `s_ready` is 0. The last write drains this cycle. Next state is `KICK`.
- **`KICK`:** `ntt_start` is 1 for exactly one cycle. Next state is `RUN`.
- **`RUN`:** `s_ready` is 0. The FSM waits for `ntt_finished == 1`, then goes to `DONE`.
- **`DONE`:** `done` is 1 for one cycle. Next state is `LOAD`. Input is accepted again from the following cycle.
- **Bank mapping** for index `j`:
  - Bank = `j[LOG_CORE:0]`, so `mem_we = 1 << bank`.
  - Address = `j[LOG_N-1:LOG_CORE+1]`.
  - `j = i` unless bit-reversal is enabled (see Configuration).
- **`s_last` checking:**
  - `s_last` is compared against `(i == N-1)` on every handshake.
  - Any mismatch sets `err_last`, which stays set until reset.
  - Counting and state transitions do not depend on `s_last`.
- `ntt_finished` is ignored in every state other than `RUN`.
- Reset asserted in any state, including mid-load and `RUN`:
  - Next cycle the state is `LOAD` and the counter is 0.
  - All outputs return to their reset values.
  - Partially written banks are not cleared.

## Timing

- Reset values: `s_ready=1`, `mem_we=0`, `mem_waddr=0`, `mem_wdata=0`, `ntt_start=0`, `busy=0`, `done=0`, `err_last=0`.
- Write latency is one cycle: a handshake at cycle `t` produces `mem_we/mem_waddr/mem_wdata` at `t+1`. `mem_we` is 0 in every cycle without a preceding handshake.
- Throughput is one coefficient per cycle. `N` back-to-back beats take `N` cycles.
- For a last handshake at cycle `t`: the last write is at `t+1` (`FLUSH`), `ntt_start` at `t+2`, `RUN` from `t+3`.
- For `ntt_finished` high at cycle `u` in `RUN`: `done` at `u+1`, `s_ready=1` at `u+2`.
- `s_ready` does not depend combinationally on `s_valid`.

## Configuration

- `NTT_LOAD_BITREV_EN` defined: the mapping uses `j = bitreverse_LOG_N(i)`. This supports natural-order input for the decimation-in-time schedule.
- Not defined: `j = i`, i.e. the input is already in bank order. No reversal logic is instantiated.

## Structure

- Shared package `ntt_pkg` holds:
  - the `LOG_N`/`LOG_CORE` defaults and the `NB`/`AW` derivations;
  - the `load_state_t` enum (`LOAD`, `FLUSH`, `KICK`, `RUN`, `DONE`);
  - a bit-reverse function.
- One combinational sub-module, `ntt_bank_map`, converts index `i` into the one-hot bank enable and address. Optional reversal is applied inside it.

## Test plan

All scenarios use `LOG_N=6`, `LOG_CORE=1`, `COEF_W=32`, giving `N=64`, 4 banks, `AW=4`.

- Reset, then stream 64 beats with `s_data=i` and `s_last` on beat 63:
  - beat 37 → `mem_we=4'b0010`, `mem_waddr=9`, `mem_wdata=37`;
  - single `ntt_start` exactly 2 cycles after the last handshake;
  - `err_last=0`.
- `s_valid` toggled every other cycle → exactly 64 writes, with no write in idle cycles; `s_ready` stays 1 throughout.
- In `RUN`, hold `ntt_finished=0` for 20 cycles, then raise it for 1 cycle → `s_ready=0` for all 20 cycles; `done` pulses 1 cycle later; `s_ready=1` the cycle after that.
- `s_last` asserted on beat 10 → `err_last=1` from the next cycle and stays 1; `ntt_start` still fires after beat 63.
- Reset pulsed after 30 beats → next cycle the count is 0 and `mem_we=0`; a new 64-beat stream completes normally.
- With `NTT_LOAD_BITREV_EN` defined, beat 37 → `j=41`, `mem_we=4'b0010`, `mem_waddr=10`.
